multibyte_add_seq: RTL and testbench

//  Byte-serial wide adder/subtractor sequencer. Accepts NUM_BYTES-wide operands over a

---
 rtl/multibyte_add_seq.sv | 116 +++++++++++
 tb/tb_multibyte_add_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide add/sub sequencer around one adder_8bit.
// LSB byte first, carry registered between bytes.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
endmodule

module multibyte_add_seq #(
  parameter int NUM_BYTES = 4,
  parameter int W = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_carry,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_carry,
  output logic         out_ovf
);
  localparam int IW = $clog2(NUM_BYTES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          cy_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  res_r;

  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_ci;
  logic [7:0]    add_s;
  logic          add_co;
  logic [W+7:0]  res_cat;

  // Operands shift right each byte, so the live byte is always [7:0].
  assign add_a   = (state == RUN) ? a_r[7:0] : 8'd0;
  assign add_b   = (state == RUN) ? b_r[7:0] : 8'd0;
  assign add_ci  = (state == RUN) ? cy_r : 1'b0;
  assign res_cat = {add_s, res_r};
  assign in_ready = (state == IDLE);

  adder_8bit u_add (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (add_ci),
    .sum       (add_s),
    .carry_out (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cy_r      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_sub ? ~in_b : in_b;
            cy_r  <= in_sub ? 1'b1 : in_carry;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_r <= res_cat[W+7:8];
          cy_r  <= add_co;
          a_r   <= a_r >> 8;
          b_r   <= b_r >> 8;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            out_sum   <= res_cat[W+7:8];
            out_carry <= add_co;
            out_ovf   <= (a_r[7] == b_r[7]) && (add_s[7] != a_r[7]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: directed cases plus random ops
// against an arithmetic reference model.
module tb_multibyte_add_seq;
  localparam int NB = 4;
  localparam int W = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_carry = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multibyte_add_seq #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, carry, sum} from signed/unsigned arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin,
                                         input logic sub);
    logic [W:0]   r;
    logic         ov;
    longint       sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      sr = sa - sb;
    end else begin
      r  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      sr = sa + sb + longint'(cin);
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, r[W], r[W-1:0]};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_carry = cin;
    in_sub = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input int hold, input logic poke);
    logic [W+1:0] exp;
    logic [W-1:0] s0;
    logic         c0, v0;
    int           lat;
    exp = model(a, b, cin, sub);
    start_op(a, b, cin, sub);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      check("in_ready_busy", in_ready, 1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, NB);
    check("sum", out_sum, exp[W-1:0]);
    check("carry", out_carry, exp[W]);
    check("ovf", out_ovf, exp[W+1]);
    s0 = out_sum;
    c0 = out_carry;
    v0 = out_ovf;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_a = $urandom;
        in_b = $urandom;
      end
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready", in_ready, 1'b0);
      check("hold_out", {out_sum, out_carry, out_ovf}, {s0, c0, v0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 1'b0);
    check("ready_back", in_ready, 1'b1);
    check("idle_keep", out_sum, s0);
  endtask

  initial begin
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum", out_sum, '0);
    check("rst_flags", {out_carry, out_ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
    check("t1_sum", out_sum, 32'h0);
    check("t1_cy", out_carry, 1'b1);
    run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 1, 1'b0);
    check("t2_sum", out_sum, 32'h2345678A);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
    check("t3_ovf", {out_sum, out_carry, out_ovf}, {32'h80000000, 2'b01});
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, 1'b0);
    check("t4a", {out_sum, out_carry, out_ovf}, {32'hFFFFFFFE, 2'b00});
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, 1'b0);
    check("t4b", {out_sum, out_carry, out_ovf}, {32'h7FFFFFFF, 2'b11});

    run_op(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b0, 10, 1'b1);
    run_op(32'h00000010, 32'h00000003, 1'b0, 1'b1, 0, 1'b0);
    check("t5_next", out_sum, 32'h0000000D);

    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_sum", out_sum, '0);
    check("t6_flags", {out_carry, out_ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ready", in_ready, 1'b1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
    check("t6_redo", {out_sum, out_carry, out_ovf}, {32'h0, 2'b10});

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) ra = {1'b0, ra[W-2:0]} | 32'h7FFF0000;
      run_op(ra, rb, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
